pulse_burst_writer: RTL and testbench
=====================================

Name: pulse_burst_writer

Overview:
- Consumes the asynchronous simulation/stimulus pulse from the pulse generator stage and turns each active edge into a fixed-length burst of FIFO writes.
- The write data comes from a free-running sequence counter that persists across bursts.
- Sits between the pulse source and the counter-and-FIFO datapath. It drives the FIFO write side and honours FIFO full back-pressure.

Parameters:
- DATA_WIDTH, 32, width of FIFO_DATA and the sequence counter (≥ 2).
- BURST_LEN, 16, words written per detected edge (1 to 65535).
- START_VALUE, 0, sequence counter value after reset (truncated to DATA_WIDTH).
- ACTIVE_HIGH, 1, 1 = rising edge of PULSE_IN triggers; 0 = falling edge triggers.

Ports:
- CLK, in, 1, single clock domain; all logic on rising edge.
- RESETN, in, 1, synchronous active-low reset; sampled on CLK rising edge.
- PULSE_IN, in, 1, asynchronous trigger from the pulse generator.
- FIFO_FULL, in, 1, FIFO full flag, synchronous to CLK.
- FIFO_WE, out, 1, FIFO write enable; a write occurs on each CLK edge where it is 1.
- FIFO_DATA, out, DATA_WIDTH, write data; valid whenever FIFO_WE=1.
- BUSY, out, 1, high while a burst is in progress.
- DONE, out, 1, single-cycle pulse when a burst completes.
- OVERRUN, out, 1, sticky: an edge was detected while not IDLE.
- BURST_COUNT, out, 16, number of completed bursts; wraps 65535→0.

Behaviour:
- Reset (RESETN=0 at a CLK edge) returns every register to its reset value regardless of state.
  - FIFO_WE=0, BUSY=0, DONE=0, OVERRUN=0, BURST_COUNT=0.
  - FIFO_DATA=START_VALUE; FSM=IDLE; word counter=0.
  - Synchroniser flops go to the inactive level (0 if ACTIVE_HIGH, else 1).
  - Reset mid-burst abandons the burst; no DONE is issued.
- Synchroniser: PULSE_IN passes through 2 flops (s1, s2), plus a history flop s3.
  - edge = s2 & ~s3 (ACTIVE_HIGH=1), or ~s2 & s3 (ACTIVE_HIGH=0).
  - A pulse held active across reset release yields exactly one edge.
- FSM states IDLE, BURST, FIN:
  - IDLE: edge → BURST, word counter loaded with BURST_LEN. Otherwise stay in IDLE.
  - BURST: BUSY=1 and FIFO_WE = ~FIFO_FULL (combinational from registered state and FIFO_FULL).
    - On a write cycle: FIFO_DATA increments by 1 (modulo 2^DATA_WIDTH; wraps all-ones→0 silently) and the word counter decrements by 1.
    - Write with word counter==1 → FIN.
    - FIFO_FULL=1 stalls: no write, FIFO_DATA and the counter hold. A stall has no timeout.
  - FIN: one cycle. DONE=1, BUSY=0, BURST_COUNT increments by 1, then → IDLE.
- FIFO_DATA holds its value between bursts; the next burst continues the sequence.
- Latency: first CLK edge sampling PULSE_IN active = cycle 0. edge=1 in cycle 2; FIFO_WE=1 in cycle 3 if not full.
- Unstalled burst: exactly BURST_LEN consecutive FIFO_WE cycles, then DONE in the following cycle.
- Edge detected in BURST or FIN: discarded, OVERRUN←1. OVERRUN clears only by reset.
- The FSM is back in IDLE the cycle after FIN. An edge in that cycle starts a new burst normally.
- Pulses shorter than 2 CLK periods may be missed; no requirement applies to them.

Test Plan:
1. CLK=10 ns, BURST_LEN=16, FIFO_FULL=0; PULSE_IN high at 500 ns for 500 ns → FIFO_WE high 16 consecutive cycles starting 3 cycles after the first sampling edge. FIFO_DATA=0..15, then DONE for 1 cycle, BURST_COUNT=1, OVERRUN=0.
2. Second pulse after the first completes → data 16..31, BURST_COUNT=2.
3. FIFO_FULL forced high for 5 cycles after the 4th write → FIFO_WE=0 during the stall, FIFO_DATA holds at 4. Total writes still 16, DONE delayed by 5 cycles.
4. Pulse falls and rises again mid-burst → burst unaffected (exactly 16 writes), OVERRUN=1 and stays 1 until reset.
5. RESETN=0 for 1 cycle after the 8th write → FIFO_WE=0, BUSY=0, FIFO_DATA=START_VALUE, BURST_COUNT=0, no DONE. The next pulse gives a full burst from START_VALUE.
6. BURST_LEN=1, DATA_WIDTH=4, START_VALUE=15, ACTIVE_HIGH=0, falling edge on PULSE_IN → single write with data 15, DONE next cycle, FIFO_DATA wraps to 0; next burst writes 0.

Source files
------------

// File: rtl/pulse_burst_writer.sv
// -----------------------------------------------------------------------------
// pulse_burst_writer
//
// Purpose:
//   Turns each active edge of an asynchronous trigger pulse into a fixed-length
//   burst of FIFO writes. Write data comes from a free-running sequence counter
//   that keeps counting across bursts. FIFO full back-pressure stalls the burst
//   without limit. An edge that arrives while a burst is still running is
//   dropped and recorded in a sticky overrun flag.
//
// Parameters:
//   DATA_WIDTH  - width of FIFO_DATA and of the sequence counter (>= 2)
//   BURST_LEN   - words written per detected edge (1..65535)
//   START_VALUE - sequence counter value after reset (truncated to DATA_WIDTH)
//   ACTIVE_HIGH - 1: rising edge of PULSE_IN triggers, 0: falling edge triggers
//
// Ports:
//   CLK         in   single clock, all logic on the rising edge
//   RESETN      in   synchronous active-low reset
//   PULSE_IN    in   asynchronous trigger
//   FIFO_FULL   in   FIFO full flag, synchronous to CLK
//   FIFO_WE     out  FIFO write enable (one write per CLK edge while high)
//   FIFO_DATA   out  write data, valid whenever FIFO_WE is high
//   BUSY        out  high while a burst is in progress
//   DONE        out  single-cycle pulse when a burst completes
//   OVERRUN     out  sticky: an edge was seen while not idle
//   BURST_COUNT out  number of completed bursts, wraps 65535 -> 0
// -----------------------------------------------------------------------------
module pulse_burst_writer #(
  parameter int unsigned     DATA_WIDTH  = 32,
  parameter int unsigned     BURST_LEN   = 16,
  parameter longint unsigned START_VALUE = 64'd0,
  parameter bit              ACTIVE_HIGH = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RESETN,
  input  logic                  PULSE_IN,
  input  logic                  FIFO_FULL,
  output logic                  FIFO_WE,
  output logic [DATA_WIDTH-1:0] FIFO_DATA,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  OVERRUN,
  output logic [15:0]           BURST_COUNT
);

  // FSM encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BURST = 2'd1;
  localparam logic [1:0] ST_FIN   = 2'd2;

  localparam logic [DATA_WIDTH-1:0] START_C    = DATA_WIDTH'(START_VALUE);
  localparam logic [15:0]           BURST_LEN_C = 16'(BURST_LEN);
  localparam logic [DATA_WIDTH-1:0] DATA_ONE_C = DATA_WIDTH'(1);

  // Synchroniser flops rest at the inactive level so that a pulse already
  // active when reset releases still produces exactly one edge.
  localparam logic INACTIVE_C = ACTIVE_HIGH ? 1'b0 : 1'b1;

  // Synchroniser and edge-history registers
  logic s1_q;
  logic s2_q;
  logic s3_q;

  // Control and datapath registers
  logic [1:0]            state_q;
  logic [1:0]            state_d;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] data_d;
  logic [15:0]           word_cnt_q;
  logic [15:0]           word_cnt_d;
  logic [15:0]           burst_cnt_q;
  logic [15:0]           burst_cnt_d;
  logic                  overrun_q;
  logic                  overrun_d;

  // Combinational decodes
  logic pulse_edge_s;
  logic busy_s;
  logic write_s;

  // Two-flop synchroniser for PULSE_IN plus one history flop for edge detection
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      s1_q <= INACTIVE_C;
      s2_q <= INACTIVE_C;
      s3_q <= INACTIVE_C;
    end else begin
      s1_q <= PULSE_IN;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  // Edge detect on the synchronised pulse and burst-phase decodes
  always_comb begin
    pulse_edge_s = 1'b0;
    busy_s       = 1'b0;
    write_s      = 1'b0;
    if (ACTIVE_HIGH) begin
      pulse_edge_s = s2_q & ~s3_q;
    end else begin
      pulse_edge_s = ~s2_q & s3_q;
    end
    busy_s  = (state_q == ST_BURST);
    // A write happens only in the burst state when the FIFO has room.
    write_s = busy_s & ~FIFO_FULL;
  end

  // Next-state logic for the FSM, sequence counter, word counter and flags
  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    word_cnt_d  = word_cnt_q;
    burst_cnt_d = burst_cnt_q;
    overrun_d   = overrun_q;

    case (state_q)
      ST_IDLE: begin
        if (pulse_edge_s) begin
          state_d    = ST_BURST;
          word_cnt_d = BURST_LEN_C;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_BURST: begin
        // Edges during a burst are dropped; only the sticky flag remembers.
        if (pulse_edge_s) begin
          overrun_d = 1'b1;
        end else begin
          overrun_d = overrun_q;
        end
        if (write_s) begin
          // Sequence wraps from all-ones to zero by natural overflow.
          data_d     = data_q + DATA_ONE_C;
          word_cnt_d = word_cnt_q - 16'd1;
          if (word_cnt_q == 16'd1) begin
            state_d = ST_FIN;
          end else begin
            state_d = ST_BURST;
          end
        end else begin
          // Full FIFO: hold data and count, wait indefinitely.
          state_d = ST_BURST;
        end
      end

      ST_FIN: begin
        if (pulse_edge_s) begin
          overrun_d = 1'b1;
        end else begin
          overrun_d = overrun_q;
        end
        burst_cnt_d = burst_cnt_q + 16'd1;
        state_d     = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state_q     <= ST_IDLE;
      data_q      <= START_C;
      word_cnt_q  <= 16'd0;
      burst_cnt_q <= 16'd0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      word_cnt_q  <= word_cnt_d;
      burst_cnt_q <= burst_cnt_d;
      overrun_q   <= overrun_d;
    end
  end

  // Output drive: decodes of registered state, plus the full-gated write enable
  always_comb begin
    FIFO_WE     = write_s;
    FIFO_DATA   = data_q;
    BUSY        = busy_s;
    DONE        = (state_q == ST_FIN);
    OVERRUN     = overrun_q;
    BURST_COUNT = burst_cnt_q;
  end

endmodule

// File: tb/tb_pulse_burst_writer.sv
// -----------------------------------------------------------------------------
// tb_pulse_burst_writer
//
// Purpose:
//   Self-checking bench for pulse_burst_writer. Instance A uses the default
//   configuration (32-bit data, 16-word bursts, rising-edge trigger); instance
//   B uses a 4-bit counter, single-word bursts starting at 15 and a
//   falling-edge trigger. A small model tracks the expected next sequence
//   value, completed burst count and overrun flag.
// -----------------------------------------------------------------------------
module tb_pulse_burst_writer;

  localparam int BL_A = 16;

  logic clk = 1'b0;
  logic rstn;

  logic        pulse_a, full_a, we_a, busy_a, done_a, ovr_a;
  logic [31:0] data_a;
  logic [15:0] cnt_a;

  logic        pulse_b, full_b, we_b, busy_b, done_b, ovr_b;
  logic [3:0]  data_b;
  logic [15:0] cnt_b;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [31:0] exp_data_a;
  logic [15:0] exp_cnt_a;
  logic        exp_ovr_a;
  logic [3:0]  exp_data_b;
  logic [15:0] exp_cnt_b;

  int  k_b;
  bit  busy_again;

  always #5 clk = ~clk;

  pulse_burst_writer #(
    .DATA_WIDTH (32),
    .BURST_LEN  (16),
    .START_VALUE(64'd0),
    .ACTIVE_HIGH(1'b1)
  ) u_dut_a (
    .CLK        (clk),
    .RESETN     (rstn),
    .PULSE_IN   (pulse_a),
    .FIFO_FULL  (full_a),
    .FIFO_WE    (we_a),
    .FIFO_DATA  (data_a),
    .BUSY       (busy_a),
    .DONE       (done_a),
    .OVERRUN    (ovr_a),
    .BURST_COUNT(cnt_a)
  );

  pulse_burst_writer #(
    .DATA_WIDTH (4),
    .BURST_LEN  (1),
    .START_VALUE(64'd15),
    .ACTIVE_HIGH(1'b0)
  ) u_dut_b (
    .CLK        (clk),
    .RESETN     (rstn),
    .PULSE_IN   (pulse_b),
    .FIFO_FULL  (full_b),
    .FIFO_WE    (we_b),
    .FIFO_DATA  (data_b),
    .BUSY       (busy_b),
    .DONE       (done_b),
    .OVERRUN    (ovr_b),
    .BURST_COUNT(cnt_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  // Count sample points (negedge + 1) until BUSY rises; compare with the latency.
  task automatic wait_busy_a(input int exp_k);
    int k;
    bit seen;
    k = 0;
    seen = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      full_a = 1'b0;
      #1;
      if (busy_a === 1'b1) begin
        k = i;
        seen = 1'b1;
        break;
      end
    end
    chk("start_latency", k, exp_k);
    if (seen) begin
      chk1("first_we", we_a, 1'b1);
    end
  endtask

  // Return pulse to low for a random gap, then raise it and expect a burst start.
  task automatic trigger_a();
    @(negedge clk);
    pulse_a = 1'b0;
    repeat ($urandom_range(3, 8)) @(negedge clk);
    pulse_a = 1'b1;
    wait_busy_a(3);
  endtask

  // Follow one burst from its first BUSY sample to the idle cycle after DONE.
  task automatic run_burst_a(input int stall_at, input int stall_len, input bit rnd,
                             input bit glitch, input bit chain, input int reset_at);
    int writes, stalls, busy_cyc, stall_left;
    bit stall_started, first, fin;
    writes = 0; stalls = 0; busy_cyc = 0; stall_left = 0;
    stall_started = 1'b0; first = 1'b1; fin = 1'b0;
    if (glitch) exp_ovr_a = 1'b1;
    for (int cyc = 0; cyc < BL_A + 200; cyc++) begin
      if (!first) begin
        @(negedge clk);
        if (reset_at >= 0 && writes == reset_at) begin
          rstn = 1'b0; pulse_a = 1'b0; full_a = 1'b0;
          @(negedge clk);
          rstn = 1'b1;
          #1;
          chk1("rst_we", we_a, 1'b0);
          chk1("rst_busy", busy_a, 1'b0);
          chk1("rst_done", done_a, 1'b0);
          chk1("rst_ovr", ovr_a, 1'b0);
          chk("rst_data", data_a, 32'd0);
          chk("rst_count", 32'(cnt_a), 32'd0);
          exp_data_a = 32'd0; exp_cnt_a = 16'd0; exp_ovr_a = 1'b0;
          return;
        end
        if (stall_left > 0) begin
          full_a = 1'b1;
          stall_left--;
        end else if (stall_at >= 0 && writes == stall_at && !stall_started) begin
          full_a = 1'b1;
          stall_left = stall_len - 1;
          stall_started = 1'b1;
        end else if (rnd) begin
          full_a = ($urandom_range(0, 3) == 0);
        end else begin
          full_a = 1'b0;
        end
        if (glitch && writes == 4) pulse_a = 1'b0;
        if (glitch && writes == 8) pulse_a = 1'b1;
        if (chain && writes == 2) pulse_a = 1'b0;
        #1;
      end
      first = 1'b0;
      if (busy_a === 1'b1) begin
        busy_cyc++;
        chk1("we_vs_full", we_a, ~full_a);
        chk("data", data_a, exp_data_a);
        if (!full_a) begin
          writes++;
          exp_data_a = exp_data_a + 32'd1;
          // Raise the next trigger during the last write so its edge lands in
          // the idle cycle right after DONE.
          if (chain && writes == BL_A) pulse_a = 1'b1;
        end else begin
          stalls++;
        end
      end else begin
        fin = 1'b1;
        break;
      end
    end
    chk1("burst_finished", fin, 1'b1);
    if (fin) begin
      chk("writes", writes, BL_A);
      chk("busy_cycles", busy_cyc, BL_A + stalls);
      if (stall_at >= 0 && !rnd) chk("stall_cycles", stalls, stall_len);
      chk1("done", done_a, 1'b1);
      chk1("we_in_fin", we_a, 1'b0);
      chk1("overrun", ovr_a, exp_ovr_a);
      chk("count_in_fin", 32'(cnt_a), 32'(exp_cnt_a));
      exp_cnt_a = exp_cnt_a + 16'd1;
      @(negedge clk);
      full_a = 1'b0;
      #1;
      chk1("done_one_cycle", done_a, 1'b0);
      chk1("busy_idle", busy_a, 1'b0);
      chk("burst_count", 32'(cnt_a), 32'(exp_cnt_a));
      chk("data_hold", data_a, exp_data_a);
    end
  endtask

  // Abort the run if something stalls beyond any reasonable bound.
  initial begin
    #2ms;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; pulse_a = 1'b0; full_a = 1'b0; pulse_b = 1'b1; full_b = 1'b0;
    exp_data_a = 32'd0; exp_cnt_a = 16'd0; exp_ovr_a = 1'b0;
    exp_data_b = 4'hF; exp_cnt_b = 16'd0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    #1;
    // Reset state
    chk1("reset_we", we_a, 1'b0);
    chk1("reset_busy", busy_a, 1'b0);
    chk1("reset_done", done_a, 1'b0);
    chk1("reset_ovr", ovr_a, 1'b0);
    chk("reset_data", data_a, 32'd0);
    chk("reset_count", 32'(cnt_a), 32'd0);
    chk("reset_data_b", 32'(data_b), 32'd15);
    chk1("reset_we_b", we_b, 1'b0);

    // Plain bursts: 0..15 then 16..31
    trigger_a(); run_burst_a(-1, 0, 1'b0, 1'b0, 1'b0, -1);
    trigger_a(); run_burst_a(-1, 0, 1'b0, 1'b0, 1'b0, -1);
    // Five-cycle stall after the fourth write
    trigger_a(); run_burst_a(4, 5, 1'b0, 1'b0, 1'b0, -1);
    // Pulse drops and rises mid-burst: overrun becomes sticky
    trigger_a(); run_burst_a(-1, 0, 1'b0, 1'b1, 1'b0, -1);
    // Random back-pressure; next edge lands in the idle cycle after DONE
    trigger_a(); run_burst_a(-1, 0, 1'b1, 1'b0, 1'b1, -1);
    wait_busy_a(1);
    run_burst_a(-1, 0, 1'b1, 1'b0, 1'b0, -1);
    // Reset after the eighth write abandons the burst
    trigger_a(); run_burst_a(-1, 0, 1'b0, 1'b0, 1'b0, 8);
    trigger_a(); run_burst_a(-1, 0, 1'b0, 1'b0, 1'b0, -1);

    // Pulse held active across reset release yields exactly one burst
    @(negedge clk); rstn = 1'b0;
    @(negedge clk); rstn = 1'b1;
    exp_data_a = 32'd0; exp_cnt_a = 16'd0; exp_ovr_a = 1'b0;
    wait_busy_a(3);
    run_burst_a(-1, 0, 1'b0, 1'b0, 1'b0, -1);
    busy_again = 1'b0;
    repeat (10) begin
      @(negedge clk); #1;
      if (busy_a === 1'b1) busy_again = 1'b1;
    end
    chk1("single_edge_after_reset", busy_again, 1'b0);

    // Randomised bursts
    for (int n = 0; n < 3; n++) begin
      trigger_a(); run_burst_a(-1, 0, 1'b1, 1'b0, 1'b0, -1);
    end

    // Instance B: falling-edge trigger, single-word bursts, 4-bit wrap
    for (int n = 0; n < 2; n++) begin
      @(negedge clk); pulse_b = 1'b1;
      repeat (4) @(negedge clk);
      pulse_b = 1'b0;
      k_b = 0;
      for (int i = 1; i <= 20; i++) begin
        @(negedge clk); #1;
        if (busy_b === 1'b1) begin
          k_b = i;
          break;
        end
      end
      chk("b_latency", k_b, 3);
      chk1("b_we", we_b, 1'b1);
      chk("b_data", 32'(data_b), 32'(exp_data_b));
      exp_data_b = exp_data_b + 4'd1;
      exp_cnt_b  = exp_cnt_b + 16'd1;
      @(negedge clk); #1;
      chk1("b_done", done_b, 1'b1);
      chk1("b_busy_fin", busy_b, 1'b0);
      chk1("b_we_fin", we_b, 1'b0);
      chk("b_data_next", 32'(data_b), 32'(exp_data_b));
      @(negedge clk); #1;
      chk1("b_done_one_cycle", done_b, 1'b0);
      chk("b_count", 32'(cnt_b), 32'(exp_cnt_b));
      chk1("b_ovr", ovr_b, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
